// File: rtl/seq_alu_param.sv
// seq_alu_param: WIDTH-generic multi-cycle ALU (add/sub, Booth signed multiply,
// restoring unsigned divide) sharing one FSM and datapath register set. Rev 1.0
`default_nettype none

module seq_alu_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] inbus_a,
  input  logic [WIDTH-1:0] inbus_b,
  output logic [WIDTH-1:0] outbus_lo,
  output logic [WIDTH-1:0] outbus_hi,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDSUB = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_DIV    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             sub_q, sub_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             ovf_q, ovf_d, dbz_q, dbz_d;

  logic [WIDTH-1:0] as_res;
  logic             as_ovf;
  logic [WIDTH:0]   booth_m, booth_sum;
  logic [WIDTH:0]   div_sh, div_diff, div_a;
  logic [WIDTH-1:0] div_q;
  logic             last_iter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sub_q   <= 1'b0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign last_iter = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (opcode)
            2'b10:   state_d = S_MUL;
            2'b11:   state_d = S_DIV;
            default: state_d = S_ADDSUB;
          endcase
        end
      end
      S_ADDSUB: state_d = S_DONE;
      S_MUL:    if (last_iter) state_d = S_DONE;
      S_DIV:    if ((m_q == '0) || last_iter) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    outbus_lo   = lo_q;
    outbus_hi   = hi_q;
    overflow    = ovf_q;
    div_by_zero = dbz_q;
  end

  // Add/sub reuses Q (operand A) and M (operand B) as its operand latches.
  always_comb begin
    as_res  = sub_q ? (q_q - m_q) : (q_q + m_q);
    as_ovf  = (sub_q ? (q_q[WIDTH-1] != m_q[WIDTH-1]) : (q_q[WIDTH-1] == m_q[WIDTH-1]))
              && (as_res[WIDTH-1] != q_q[WIDTH-1]);
    booth_m = {m_q[WIDTH-1], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = a_q + booth_m;
      2'b10:   booth_sum = a_q - booth_m;
      default: booth_sum = a_q;
    endcase
    div_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    if (div_diff[WIDTH]) begin
      div_a = div_sh;
      div_q = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      div_a = div_diff;
      div_q = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    sub_d = sub_q;
    a_d   = a_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sub_d = opcode[0];
          a_d   = '0;
          q_d   = inbus_a;
          qm1_d = 1'b0;
          m_d   = inbus_b;
          cnt_d = CW'(WIDTH);
          ovf_d = 1'b0;
          dbz_d = 1'b0;
        end
      end
      S_ADDSUB: begin
        lo_d  = as_res;
        hi_d  = '0;
        ovf_d = as_ovf;
      end
      S_MUL: begin
        a_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          hi_d = booth_sum[WIDTH:1];
          lo_d = {booth_sum[0], q_q[WIDTH-1:1]};
        end
      end
      S_DIV: begin
        if (m_q == '0) begin
          dbz_d = 1'b1;
          lo_d  = '1;
          hi_d  = q_q;
        end else begin
          a_d   = div_a;
          q_d   = div_q;
          cnt_d = cnt_q - CW'(1);
          if (last_iter) begin
            lo_d = div_q;
            hi_d = div_a[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu_param.sv
// tb_seq_alu_param: directed table, corner sequences and random ops against an
// arithmetic reference model, on WIDTH=8 and WIDTH=16 instances.
`default_nettype none

module tb_seq_alu_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st8 = 1'b0, st16 = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0, b_i = '0;

  logic [7:0]  lo8, hi8;
  logic [15:0] lo16, hi16;
  logic        busy8, done8, ovf8, dbz8;
  logic        busy16, done16, ovf16, dbz16;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  seq_alu_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .opcode(op_i),
    .inbus_a(a_i[7:0]), .inbus_b(b_i[7:0]),
    .outbus_lo(lo8), .outbus_hi(hi8), .busy(busy8), .done(done8),
    .overflow(ovf8), .div_by_zero(dbz8)
  );

  seq_alu_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .opcode(op_i),
    .inbus_a(a_i[15:0]), .inbus_b(b_i[15:0]),
    .outbus_lo(lo16), .outbus_hi(hi16), .busy(busy16), .done(done16),
    .overflow(ovf16), .div_by_zero(dbz16)
  );

  typedef struct {
    longint lo;
    longint hi;
    bit     ovf;
    bit     dbz;
    int     lat;
  } exp_t;

  typedef struct {
    int          w;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  function automatic longint g_lo(int w); return (w == 8) ? longint'(lo8) : longint'(lo16); endfunction
  function automatic longint g_hi(int w); return (w == 8) ? longint'(hi8) : longint'(hi16); endfunction
  function automatic bit g_busy(int w); return (w == 8) ? busy8 : busy16; endfunction
  function automatic bit g_done(int w); return (w == 8) ? done8 : done16; endfunction
  function automatic bit g_ovf(int w);  return (w == 8) ? ovf8 : ovf16; endfunction
  function automatic bit g_dbz(int w);  return (w == 8) ? dbz8 : dbz16; endfunction

  // Reference: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic exp_t model(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t   e;
    longint mask = (longint'(1) << w) - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    longint sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -(longint'(1) << (w - 1));
    longint r;
    e.ovf = 0; e.dbz = 0; e.hi = 0; e.lat = w;
    case (op)
      2'd0, 2'd1: begin
        r     = (op == 2'd0) ? sa + sb : sa - sb;
        e.lo  = r & mask;
        e.ovf = (r > mx) || (r < mn);
        e.lat = 1;
      end
      2'd2: begin
        r    = sa * sb;
        e.lo = r & mask;
        e.hi = (r >>> w) & mask;
      end
      default: begin
        if (ub == 0) begin
          e.lo = mask; e.hi = ua; e.dbz = 1; e.lat = 1;
        end else begin
          e.lo = ua / ub; e.hi = ua % ub;
        end
      end
    endcase
    return e;
  endfunction

  function automatic vec_t mk(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                              longint lo, longint hi, bit ovf, bit dbz, int lat);
    vec_t v;
    v.w = w; v.op = op; v.a = a; v.b = b;
    v.e.lo = lo; v.e.hi = hi; v.e.ovf = ovf; v.e.dbz = dbz; v.e.lat = lat;
    return v;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b, output int acc);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b;
    if (w == 8) st8 = 1'b1; else st16 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0; st16 = 1'b0;
    acc = cyc_cnt;
  endtask

  task automatic wait_done(int w, output bit seen);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      if (g_done(w)) seen = 1;
    end
  endtask

  task automatic finish_checks(string name, int w, int acc, exp_t e);
    bit seen;
    wait_done(w, seen);
    chk({name, " done_seen"}, seen, 1);
    chk({name, " latency"}, cyc_cnt - acc, e.lat);
    chk({name, " lo"}, g_lo(w), e.lo);
    chk({name, " hi"}, g_hi(w), e.hi);
    chk({name, " ovf"}, g_ovf(w), e.ovf);
    chk({name, " dbz"}, g_dbz(w), e.dbz);
    @(posedge clk); #1;
    chk({name, " done_pulse"}, g_done(w), 0);
    chk({name, " busy_drop"}, g_busy(w), 0);
  endtask

  task automatic run_op(string name, int w, logic [1:0] op, logic [31:0] a, logic [31:0] b, exp_t e);
    int acc;
    issue(w, op, a, b, acc);
    chk({name, " busy"}, g_busy(w), 1);
    finish_checks(name, w, acc, e);
  endtask

  vec_t tbl[12];

  initial begin
    int   acc;
    int   pulses;
    exp_t e;

    tbl[0]  = mk(8,  2'd0, 100,   27,   127,    0,      0, 0, 1);
    tbl[1]  = mk(8,  2'd0, 100,   28,   'h80,   0,      1, 0, 1);
    tbl[2]  = mk(8,  2'd1, 5,     7,    'hFE,   0,      0, 0, 1);
    tbl[3]  = mk(8,  2'd1, 'h80,  1,    'h7F,   0,      1, 0, 1);
    tbl[4]  = mk(8,  2'd2, 'hF9,  9,    'hC1,   'hFF,   0, 0, 8);
    tbl[5]  = mk(8,  2'd2, 'h80,  'h80, 'h00,   'h40,   0, 0, 8);
    tbl[6]  = mk(8,  2'd3, 200,   7,    28,     4,      0, 0, 8);
    tbl[7]  = mk(8,  2'd3, 13,    0,    'hFF,   13,     0, 1, 1);
    tbl[8]  = mk(8,  2'd0, 1,     1,    2,      0,      0, 0, 1);
    tbl[9]  = mk(16, 2'd2, 300,   'hFFFE, 'hFDA8, 'hFFFF, 0, 0, 16);
    tbl[10] = mk(16, 2'd3, 65535, 256,  255,    255,    0, 0, 16);
    tbl[11] = mk(16, 2'd0, 'h7FFF, 1,   'h8000, 0,      1, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst busy8", busy8, 0);
    chk("rst done8", done8, 0);
    chk("rst lo8", lo8, 0);
    chk("rst hi8", hi8, 0);
    chk("rst flags8", {ovf8, dbz8}, 0);
    chk("rst busy16", busy16, 0);
    chk("rst lo16", lo16, 0);

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);

    // start while busy must not disturb the multiply in flight
    issue(8, 2'd2, 3, 5, acc);
    repeat (2) @(posedge clk);
    @(negedge clk); op_i = 2'd0; a_i = 7; b_i = 7; st8 = 1'b1;
    @(negedge clk); st8 = 1'b0;
    e = model(8, 2'd2, 3, 5);
    finish_checks("ignore_start", 8, acc, e);

    // reset mid-multiply: aborts with cleared outputs and no done pulse
    issue(8, 2'd2, 5, 5, acc);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", busy8, 0);
    chk("midrst done", done8, 0);
    chk("midrst lo", lo8, 0);
    chk("midrst hi", hi8, 0);
    @(negedge clk) reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    chk("midrst no_done", pulses, 0);

    for (int n = 0; n < 60; n++) begin
      int          w;
      logic [1:0]  op;
      logic [31:0] a, b;
      w  = ($urandom_range(0, 1) == 0) ? 8 : 16;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      e  = model(w, op, a, b);
      run_op($sformatf("rnd%0d w%0d op%0d a%0h b%0h", n, w, op, a, b), w, op, a, b, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_alu_param.md
Name: seq_alu_param

Overview:
Parametrised multi-cycle integer ALU. It replaces the fixed 8-bit add/sub/Booth/restoring-divide unit with a WIDTH-generic core built around one shared FSM. It returns full-width results: the 2*WIDTH product, and the quotient and remainder together. It adds busy, divide-by-zero and signed-overflow status flags. It sits between the operand buses and the result bus; the host drives start and waits for done.

Parameters:
WIDTH, 8, operand and result-half width in bits; legal range 4..32.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
opcode  input  2  operation: 00 add, 01 sub, 10 signed multiply, 11 unsigned divide.
inbus_a  input  WIDTH  operand A (minuend, multiplier or dividend).
inbus_b  input  WIDTH  operand B (subtrahend, multiplicand or divisor).
outbus_lo  output  WIDTH  sum/difference, product low half, or quotient.
outbus_hi  output  WIDTH  zero for add/sub, product high half, or remainder.
busy  output  1  high from the accept edge until the DONE state is left.
done  output  1  one-cycle pulse; the result is valid in that cycle.
overflow  output  1  signed overflow of add/sub; 0 for mul and div.
div_by_zero  output  1  set when a divide is issued with inbus_b == 0.

Behaviour:
- Reset is synchronous, active-high, and wins over everything, including mid-operation.
  - Next state is IDLE.
  - busy, done, overflow, div_by_zero = 0; outbus_lo, outbus_hi = 0.
  - Internal registers A, Q, Q_-1, M and the counter are cleared.
- States: IDLE, ADDSUB, MUL, DIV, DONE.
- IDLE:
  - If start=1, latch opcode, inbus_a and inbus_b.
  - Clear overflow and div_by_zero.
  - Set busy=1 and branch: ADDSUB (00/01), MUL (10), DIV (11).
  - Later changes on the input buses or opcode have no effect until the next accept.
- ADDSUB (1 cycle):
  - Compute A±B as WIDTH-bit two's complement into outbus_lo; outbus_hi=0.
  - overflow = signed overflow (operand signs agree for add, or differ for sub, and the result sign differs from A).
  - Go to DONE.
- MUL (radix-2 Booth, signed):
  - Initialise A=0, Q=operand A, Q_-1=0, counter=WIDTH.
  - Each cycle: inspect {Q0,Q_-1}. 01 → A+=M; 10 → A-=M; 00/11 → no add.
  - Then arithmetic-shift right {A,Q,Q_-1} by one and decrement the counter.
  - When the counter reaches 0: {outbus_hi,outbus_lo}={A,Q}; go to DONE.
  - The A adder is WIDTH+1 bits so that -2^(WIDTH-1) × -2^(WIDTH-1) is exact.
- DIV (restoring, unsigned):
  - Divisor zero: skip iteration. Set div_by_zero=1, outbus_lo=all ones, outbus_hi=dividend; go to DONE.
  - Otherwise: A=0, Q=dividend, counter=WIDTH.
  - Each cycle: shift {A,Q} left by one; A-=M.
  - If the new A is negative, restore A+=M and set Q0=0; else Q0=1. Decrement the counter.
  - When the counter reaches 0: outbus_lo=Q, outbus_hi=A; go to DONE.
- DONE (1 cycle):
  - done=1, then go to IDLE; busy drops on that edge.
  - start during DONE is ignored.
- Outputs hold their last result and flags in IDLE until the next accept.
- Latency, accept edge to the edge that raises done:
  - add/sub: 1.
  - divide by zero: 1.
  - mul: WIDTH.
  - div: WIDTH.
  - done is then high for exactly one cycle.
- start while busy=1: ignored, with no queueing and no effect on the operation in flight.
- Back-to-back throughput: start may be accepted in the IDLE cycle immediately after DONE.
- The counter is $clog2(WIDTH)+1 bits wide; it never wraps.

Test Plan:
1. WIDTH=8, add 100+27 → lo=127, hi=0, overflow=0, done 1 cycle after accept. Then add 100+28 → lo=0x80, overflow=1.
2. WIDTH=8, sub 5-7 → lo=0xFE, hi=0x00, overflow=0. Sub 0x80-0x01 → lo=0x7F, overflow=1.
3. WIDTH=8, mul -7×9 → {hi,lo}=0xFFC1, done 8 cycles after accept. mul -128×-128 → 0x4000.
4. WIDTH=8, div 200/7 → lo=28, hi=4, div_by_zero=0, done 8 cycles after accept. div 13/0 → lo=0xFF, hi=13, div_by_zero=1, done after 1 cycle.
5. Start a mul, pulse start with different operands at cycle 3 → ignored, original result returned. Start a new mul, assert reset at cycle 4 → next cycle busy=0, outputs=0, no done pulse.
6. WIDTH=16, mul 300×-2 → {hi,lo}=0xFFFFFDA8 after 16 cycles. Then immediately issue div 65535/256 → lo=255, hi=255.
